// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD registered read ports, two prioritised write ports (port 1 wins).
// Define REGFILE_BYPASS_EN to forward same-edge write data to the read ports.
module regfile_mp #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 5,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we0,
    input  logic [AWIDTH-1:0]        wa0,
    input  logic [DWIDTH-1:0]        wd0,
    input  logic                     we1,
    input  logic [AWIDTH-1:0]        wa1,
    input  logic [DWIDTH-1:0]        wd1,
    input  logic [NREAD-1:0]         re,
    input  logic [NREAD*AWIDTH-1:0]  ra,
    output logic [NREAD*DWIDTH-1:0]  rd
);

    // One extra bit so DEPTH == 2**AWIDTH is representable in the range check.
    localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH+1)'(DEPTH);
    localparam bit              ZR      = (ZERO_REG != 0);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic              wr0_ok;
    logic              wr1_ok;

    assign wr0_ok = we0 && ({1'b0, wa0} < DEPTH_L) && !(ZR && (wa0 == '0));
    assign wr1_ok = we1 && ({1'b0, wa1} < DEPTH_L) && !(ZR && (wa1 == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem[j] <= '0;
            end
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                if (wr1_ok && (wa1 == AWIDTH'(j))) begin
                    mem[j] <= wd1;
                end else if (wr0_ok && (wa0 == AWIDTH'(j))) begin
                    mem[j] <= wd0;
                end
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AWIDTH-1:0] ra_i;
        logic              in_range;
        logic [DWIDTH-1:0] rnext;
        logic [DWIDTH-1:0] rq;

        assign ra_i     = ra[i*AWIDTH +: AWIDTH];
        assign in_range = ({1'b0, ra_i} < DEPTH_L) && !(ZR && (ra_i == '0));

        // Decoded mux rather than mem[ra_i] so unmapped addresses never produce X.
        always_comb begin
            rnext = '0;
            if (in_range) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (ra_i == AWIDTH'(j)) begin
                        rnext = mem[j];
                    end
                end
`ifdef REGFILE_BYPASS_EN
                if (wr1_ok && (wa1 == ra_i)) begin
                    rnext = wd1;
                end else if (wr0_ok && (wa0 == ra_i)) begin
                    rnext = wd0;
                end
`endif
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rq <= '0;
            end else if (re[i]) begin
                rq <= rnext;
            end
        end

        assign rd[i*DWIDTH +: DWIDTH] = rq;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (DEPTH=24, NREAD=3, ZERO_REG=1).
// Expected values for same-cycle reads follow whether REGFILE_BYPASS_EN is defined.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           we0 = 1'b0;
    logic [AW-1:0]  wa0 = '0;
    logic [DW-1:0]  wd0 = '0;
    logic           we1 = 1'b0;
    logic [AW-1:0]  wa1 = '0;
    logic [DW-1:0]  wd1 = '0;
    logic [NR-1:0]  re  = '0;
    logic [NR*AW-1:0] ra = '0;
    logic [NR*DW-1:0] rd;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(24), .NREAD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .re(re), .ra(ra), .rd(rd)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rdp(input int i);
        return rd[i*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0;
        we1 = 1'b0;
        re  = '0;
    endtask

    task automatic set_ra(input int i, input logic [AW-1:0] a);
        ra[i*AW +: AW] = a;
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we0 = 1'b1; wa0 = a; wd0 = d;
    endtask

    task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we1 = 1'b1; wa1 = a; wd1 = d;
    endtask

    task automatic test_reset();
        logic [DW-1:0] v;
        rst = 1'b1;
        #12;
        for (int i = 0; i < NR; i++) begin
            v = rdp(i);
            n_checks++;
            if (v !== '0) begin
                n_fail++;
                $display("FAIL reset_rd%0d: got %h expected %h", i, v, 32'h0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        idle();
        wr0(5'd5, 32'hDEADBEEF);
        tick();
        idle();
        re = 3'b001; set_ra(0, 5'd5);
        tick();
        v = rdp(0);
        n_checks++;
        if (v !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL pre_reset_read_x5: got %h expected %h", v, 32'hDEADBEEF);
        end
        idle();
        rst = 1'b1;
        #2;
        v = rdp(0);
        n_checks++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL async_clear_rd0: got %h expected %h", v, 32'h0);
        end
        rst = 1'b0;
        re = 3'b001; set_ra(0, 5'd5);
        tick();
        v = rdp(0);
        n_checks++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL post_reset_read_x5: got %h expected %h", v, 32'h0);
        end
        idle();
    endtask

    task automatic test_collision();
        logic [DW-1:0] v;
        wr0(5'd7, 32'h11);
        wr1(5'd7, 32'h22);
        tick();
        idle();
        re = 3'b010; set_ra(1, 5'd7);
        tick();
        v = rdp(1);
        n_checks++;
        if (v !== 32'h22) begin
            n_fail++;
            $display("FAIL collision_x7: got %h expected %h", v, 32'h22);
        end
        idle();
        wr0(5'd7, 32'h33);
        tick();
        idle();
        re = 3'b010; set_ra(1, 5'd7);
        tick();
        v = rdp(1);
        n_checks++;
        if (v !== 32'h33) begin
            n_fail++;
            $display("FAIL port0_only_x7: got %h expected %h", v, 32'h33);
        end
        idle();
        wr0(5'd8, 32'h88);
        wr1(5'd9, 32'h99);
        tick();
        idle();
        re = 3'b111; set_ra(0, 5'd8); set_ra(1, 5'd9); set_ra(2, 5'd7);
        tick();
        v = rdp(0);
        n_checks++;
        if (v !== 32'h88) begin
            n_fail++;
            $display("FAIL dual_diff_x8: got %h expected %h", v, 32'h88);
        end
        v = rdp(1);
        n_checks++;
        if (v !== 32'h99) begin
            n_fail++;
            $display("FAIL dual_diff_x9: got %h expected %h", v, 32'h99);
        end
        v = rdp(2);
        n_checks++;
        if (v !== 32'h33) begin
            n_fail++;
            $display("FAIL dual_diff_x7: got %h expected %h", v, 32'h33);
        end
        idle();
    endtask

    task automatic test_zero_oor();
        logic [DW-1:0] v;
        // Same-cycle read of x0 must stay 0 even with forwarding.
        wr0(5'd0, 32'hFFFFFFFF);
        wr1(5'd0, 32'hFFFFFFFF);
        re = 3'b111; set_ra(0, 5'd0); set_ra(1, 5'd0); set_ra(2, 5'd0);
        tick();
        idle();
        v = rdp(0);
        n_checks++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL x0_same_cycle: got %h expected %h", v, 32'h0);
        end
        re = 3'b111;
        tick();
        for (int i = 0; i < NR; i++) begin
            v = rdp(i);
            n_checks++;
            if (v !== '0) begin
                n_fail++;
                $display("FAIL x0_read_rd%0d: got %h expected %h", i, v, 32'h0);
            end
        end
        idle();
        wr1(5'd30, 32'h1234);
        wr0(5'd23, 32'h2323);
        tick();
        idle();
        wr1(5'd24, 32'h2424);
        re = 3'b111; set_ra(0, 5'd30); set_ra(1, 5'd23); set_ra(2, 5'd24);
        tick();
        idle();
        v = rdp(0);
        n_checks++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL oor_x30: got %h expected %h", v, 32'h0);
        end
        v = rdp(1);
        n_checks++;
        if (v !== 32'h2323) begin
            n_fail++;
            $display("FAIL last_reg_x23: got %h expected %h", v, 32'h2323);
        end
        v = rdp(2);
        n_checks++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL oor_x24: got %h expected %h", v, 32'h0);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] v;
        logic [DW-1:0] exp;
        wr0(5'd3, 32'hA);
        tick();
        idle();
        wr0(5'd3, 32'hB);
        re = 3'b111; set_ra(0, 5'd3); set_ra(1, 5'd3); set_ra(2, 5'd3);
        tick();
        idle();
        exp = BYP ? 32'hB : 32'hA;
        for (int i = 0; i < NR; i++) begin
            v = rdp(i);
            n_checks++;
            if (v !== exp) begin
                n_fail++;
                $display("FAIL bypass_same_rd%0d: got %h expected %h", i, v, exp);
            end
        end
        re = 3'b111;
        tick();
        for (int i = 0; i < NR; i++) begin
            v = rdp(i);
            n_checks++;
            if (v !== 32'hB) begin
                n_fail++;
                $display("FAIL bypass_next_rd%0d: got %h expected %h", i, v, 32'hB);
            end
        end
        idle();
        wr0(5'd3, 32'hC0);
        wr1(5'd3, 32'hC1);
        re = 3'b001;
        tick();
        idle();
        exp = BYP ? 32'hC1 : 32'hB;
        v = rdp(0);
        n_checks++;
        if (v !== exp) begin
            n_fail++;
            $display("FAIL bypass_prio: got %h expected %h", v, exp);
        end
        wr0(5'd3, 32'hD0);
        re = 3'b001;
        tick();
        idle();
        exp = BYP ? 32'hD0 : 32'hC1;
        v = rdp(0);
        n_checks++;
        if (v !== exp) begin
            n_fail++;
            $display("FAIL bypass_port0: got %h expected %h", v, exp);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] v;
        logic [DW-1:0] exp;
        wr1(5'd4, 32'h5);
        tick();
        idle();
        re = 3'b001; set_ra(0, 5'd4);
        tick();
        idle();
        v = rdp(0);
        n_checks++;
        if (v !== 32'h5) begin
            n_fail++;
            $display("FAIL stall_first_read: got %h expected %h", v, 32'h5);
        end
        for (int c = 0; c < 3; c++) begin
            if (c == 0) wr0(5'd4, 32'h9);
            re = 3'b010; set_ra(1, 5'd4);
            tick();
            idle();
            v = rdp(0);
            n_checks++;
            if (v !== 32'h5) begin
                n_fail++;
                $display("FAIL stall_hold_c%0d: got %h expected %h", c, v, 32'h5);
            end
            exp = (c == 0 && !BYP) ? 32'h5 : 32'h9;
            v = rdp(1);
            n_checks++;
            if (v !== exp) begin
                n_fail++;
                $display("FAIL stall_indep_rd1_c%0d: got %h expected %h", c, v, exp);
            end
        end
        re = 3'b001; set_ra(0, 5'd4);
        tick();
        idle();
        v = rdp(0);
        n_checks++;
        if (v !== 32'h9) begin
            n_fail++;
            $display("FAIL stall_release: got %h expected %h", v, 32'h9);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] v;
        logic [DW-1:0] exp;
        wr0(5'd10, 32'h100);
        wr1(5'd11, 32'h101);
        tick();
        idle();
        wr0(5'd12, 32'h102);
        re = 3'b111; set_ra(0, 5'd10); set_ra(1, 5'd11); set_ra(2, 5'd12);
        tick();
        idle();
        v = rdp(0);
        n_checks++;
        if (v !== 32'h100) begin
            n_fail++;
            $display("FAIL b2b_x10: got %h expected %h", v, 32'h100);
        end
        v = rdp(1);
        n_checks++;
        if (v !== 32'h101) begin
            n_fail++;
            $display("FAIL b2b_x11: got %h expected %h", v, 32'h101);
        end
        exp = BYP ? 32'h102 : 32'h0;
        v = rdp(2);
        n_checks++;
        if (v !== exp) begin
            n_fail++;
            $display("FAIL b2b_x12_same: got %h expected %h", v, exp);
        end
        wr1(5'd10, 32'h200);
        re = 3'b111; set_ra(0, 5'd12); set_ra(1, 5'd12); set_ra(2, 5'd11);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            v = rdp(i);
            n_checks++;
            if (v !== 32'h102) begin
                n_fail++;
                $display("FAIL b2b_dup_x12_rd%0d: got %h expected %h", i, v, 32'h102);
            end
        end
        re = 3'b001; set_ra(0, 5'd10);
        tick();
        idle();
        v = rdp(0);
        n_checks++;
        if (v !== 32'h200) begin
            n_fail++;
            $display("FAIL b2b_x10_new: got %h expected %h", v, 32'h200);
        end
    endtask

    initial begin
        test_reset();
        test_collision();
        test_zero_oor();
        test_bypass();
        test_stall();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the RISC-V core datapath, providing NREAD synchronous read ports and two prioritised write ports. Read data is registered (1-cycle latency), with optional same-cycle write-to-read forwarding. The block is intended for dual-writeback pipelines where the ALU writeback and a late load/CSR return may target the file in the same cycle. A hardwired-zero register, per-port read enables for stall hold, and an asynchronous clear are included.

## Interface
- DWIDTH, 32, data width per register
- AWIDTH, 5, address width
- DEPTH, 32, number of registers (≤ 2^AWIDTH)
- NREAD, 2, number of read ports (1–4)
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- we0  input  1  write enable, port 0 (low priority)
- wa0  input  AWIDTH  write address, port 0
- wd0  input  DWIDTH  write data, port 0
- we1  input  1  write enable, port 1 (high priority)
- wa1  input  AWIDTH  write address, port 1
- wd1  input  DWIDTH  write data, port 1
- re  input  NREAD  per-port read enable; port i occupies bit i
- ra  input  NREAD*AWIDTH  read addresses; port i occupies [i*AWIDTH +: AWIDTH]
- rd  output  NREAD*DWIDTH  registered read data; port i occupies [i*DWIDTH +: DWIDTH]

## Operation
- Storage: DEPTH × DWIDTH flops.
- Write qualification: a write on port k is effective iff wek=1, wak<DEPTH, and !(ZERO_REG && wak==0).
- Both ports effective on different addresses: both registers update on the same edge.
- Both ports effective on the same address: wd1 is stored and wd0 is discarded.
- Read port i, on an edge with re[i]=1, loads rd_i with the first matching case:
  - ra_i ≥ DEPTH, or ZERO_REG && ra_i==0 → 0
  - forwarding compiled in and port 1 write effective to ra_i → wd1
  - forwarding compiled in and port 0 write effective to ra_i → wd0
  - otherwise the stored value before the edge
- re[i]=0: rd_i holds its value, even if the addressed register is written.
- Read ports are fully independent. Any port may read any address, including duplicates.

## Timing
- Read latency: 1 cycle from ra/re sampled at edge N to rd valid after edge N.
- Write latency: storage updates at edge N. A read sampled at edge N+1 or later returns the new value regardless of configuration.
- rst assertion asynchronously clears all storage and all rd outputs to 0. The clear holds while rst is high.
- Writes and reads presented in the same cycle as rst deassertion take effect at the first rising edge with rst low.
- A rst pulse mid-operation discards in-flight reads. rd reads 0 until the next enabled read edge.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle forwarding as listed above, with port 1 taking priority over port 0. A read of register r at edge N with a write to r at edge N returns the new data.
- REGFILE_BYPASS_EN undefined: there is no forwarding. The same case returns the old stored value, and the new value is visible from edge N+1. The forwarding mux is absent.

## Test plan
- Reset: write 0xDEADBEEF to x5, then pulse rst between edges → rd reads 0 immediately; a later read of x5 returns 0x00000000.
- Dual write collision: we0=we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22 → the next read of x7 returns 0x22. Write 0x33 via port 0 only → the next read returns 0x33.
- Zero register and out-of-range: with ZERO_REG=1, write 0xFFFFFFFF to x0 → reads return 0. With DEPTH=24, a write to address 30 is dropped and a read of address 30 returns 0.
- Bypass: with x3=0xA, write 0xB to x3 and read x3 on all NREAD ports in the same cycle → rd=0xB with REGFILE_BYPASS_EN defined, and rd=0xA with it undefined. The following read returns 0xB in both builds.
- Stall hold: re[0]=1 reading x4=0x5, then re[0]=0 for 3 cycles while x4 is written with 0x9 → rd_0 stays 0x5. On re[0]=1, rd_0=0x9 after one edge.
- Random regression: random we/wa/wd/ra/re against a scoreboard model for 10k cycles with NREAD=3 and DWIDTH=64 → zero mismatches.
